// File: rtl/act_wr_port_pp_pkg.sv
// Shared types and helpers for the ping/pong activation SRAM write port.
// Consumed by act_wr_port_pp and act_pp_tracker.
package act_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int BANK_W_DEF = 128;
  localparam int NL         = DATA_W_DEF / BANK_W_DEF;
  localparam int SET_NUM    = 2;

  // Upper bounds for the lane helper so one function serves every parameterisation.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BANK_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Lane l of a beat, right-aligned; the caller keeps the low bank_w bits.
  function automatic logic [MAX_BANK_W-1:0] lane_of(input logic [MAX_DATA_W-1:0] beat,
                                                    input int l,
                                                    input int bank_w);
    logic [MAX_DATA_W-1:0] shifted;
    shifted = beat >> (l * bank_w);
    return shifted[MAX_BANK_W-1:0];
  endfunction

endpackage

// File: rtl/act_wr_port_pp_tracker.sv
// Ping/pong set occupancy: which set is being written, which sets await release,
// and whether the current target set is blocked.
module act_pp_tracker
  import act_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill,
  input  logic [SET_NUM-1:0] rel_i,
  output logic               wr_set,
  output logic [SET_NUM-1:0] set_full,
  output logic               stall
);

  logic               r_wr_set;
  logic [SET_NUM-1:0] r_set_full;
  logic [SET_NUM-1:0] w_full_nxt;

  // A fill wins over a release of the same set: that set was empty, so the release is stale.
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    w_full_nxt = r_set_full;
    for (int s = 0; s < SET_NUM; s++) begin
      if (fill && (r_wr_set == 1'(s))) begin
        w_full_nxt[s] = 1'b1;
      end else if (rel_i[s]) begin
        w_full_nxt[s] = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_set   <= 1'b0;
      r_set_full <= '0;
    end else begin
      r_set_full <= w_full_nxt;
      if (fill) begin
        r_wr_set <= ~r_wr_set;
      end
    end
  end

  assign wr_set   = r_wr_set;
  assign set_full = r_set_full;
  assign stall    = r_set_full[r_wr_set];

endmodule

// File: rtl/act_wr_port_pp.sv
// Activation SRAM write port with ping/pong bank sets and release-based back-pressure.
// Optional ACT_WR_PORT_FLUSH_EN adds flush/fill_addr to hand over a partially written set.
module act_wr_port_pp
  import act_pkg::*;
#(
  parameter int BANK_W        = BANK_W_DEF,
  parameter int DATA_W        = NL * BANK_W_DEF,
  parameter int ADDR_W        = 15,
  parameter int ADDR_STEP     = 16,
  parameter int PP_ADDR_LIMIT = 32752,
  parameter int CNT_W         = 13
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [CNT_W-1:0]                            tran_time,
  input  logic                                        data_valid,
  input  logic [DATA_W-1:0]                           data_i,
  output logic                                        data_ready,
  output logic                                        done,
  input  logic [SET_NUM-1:0]                          rel_i,
  output logic [SET_NUM-1:0]                          set_full,
  output logic                                        wr_set,
`ifdef ACT_WR_PORT_FLUSH_EN
  input  logic                                        flush,
  output logic [ADDR_W-1:0]                           fill_addr,
`endif
  output logic [SET_NUM*(DATA_W/BANK_W)-1:0]          bce,
  output logic [SET_NUM*(DATA_W/BANK_W)*ADDR_W-1:0]   bwaddr,
  output logic [SET_NUM*(DATA_W/BANK_W)*BANK_W-1:0]   bwdata
);

  localparam int LANES = DATA_W / BANK_W;
  localparam int BANKS = SET_NUM * LANES;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [ADDR_W-1:0]        r_addr;
  logic [BANKS-1:0]         r_bce;
  logic [BANKS*ADDR_W-1:0]  r_bwaddr;
  logic [BANKS*BANK_W-1:0]  r_bwdata;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_at_limit;
  logic                     w_flush_fire;
  logic                     w_fill;
  logic                     w_stall;
  logic                     w_wr_set;
  logic [BANKS-1:0]         w_set_mask;
  logic [MAX_DATA_W-1:0]    w_beat_ext;
  logic [BANKS*BANK_W-1:0]  w_lanes;

  assign w_ready    = (r_state == BURST) && !w_stall;
  assign w_accept   = data_valid && w_ready;
  assign w_at_limit = (r_addr == ADDR_W'(PP_ADDR_LIMIT));

`ifdef ACT_WR_PORT_FLUSH_EN
  // A start in the same cycle takes priority; an empty set has nothing to hand over.
  assign w_flush_fire = (r_state == IDLE) && !start && flush && (r_addr != '0);
`else
  assign w_flush_fire = 1'b0;
`endif

  assign w_fill = (w_accept && w_at_limit) || w_flush_fire;

  act_pp_tracker u_tracker (
    .clk      (clk),
    .rst      (rst),
    .fill     (w_fill),
    .rel_i    (rel_i),
    .wr_set   (w_wr_set),
    .set_full (set_full),
    .stall    (w_stall)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (tran_time == '0) ? DONE : BURST;
        end else if (w_flush_fire) begin
          w_state_nxt = DONE;
        end
      end
      BURST: begin
        if (w_accept && (r_cnt == CNT_W'(1))) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Enables for the set being written, and each lane replicated into both sets.
  always_comb begin
    w_set_mask = '0;
    w_beat_ext = '0;
    w_lanes    = '0;
    w_beat_ext[DATA_W-1:0] = data_i;
    for (int b = 0; b < BANKS; b++) begin
      w_set_mask[b] = ((b / LANES) == int'(w_wr_set));
    end
    for (int l = 0; l < LANES; l++) begin
      w_lanes[l*BANK_W +: BANK_W]           = BANK_W'(lane_of(w_beat_ext, l, BANK_W));
      w_lanes[(LANES+l)*BANK_W +: BANK_W]   = BANK_W'(lane_of(w_beat_ext, l, BANK_W));
    end
  end

  // Datapath: counter, persistent set address and the registered SRAM interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_addr   <= '0;
      r_bce    <= '0;
      r_bwaddr <= '0;
      r_bwdata <= '0;
    end else begin
      r_bce <= '0;
      if ((r_state == IDLE) && start) begin
        r_cnt <= tran_time;
      end
      if (w_accept) begin
        r_bce    <= w_set_mask;
        r_bwaddr <= {BANKS{r_addr}};
        r_bwdata <= w_lanes;
        r_cnt    <= r_cnt - CNT_W'(1);
        r_addr   <= w_at_limit ? '0 : r_addr + ADDR_W'(ADDR_STEP);
      end
      if (w_flush_fire) begin
        r_addr <= '0;
      end
    end
  end

`ifdef ACT_WR_PORT_FLUSH_EN
  logic [ADDR_W-1:0] r_fill_addr;

  // Last address actually written into the set being handed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_addr <= '0;
    end else if (w_flush_fire) begin
      r_fill_addr <= r_addr - ADDR_W'(ADDR_STEP);
    end
  end

  assign fill_addr = r_fill_addr;
`endif

  assign data_ready = w_ready;
  assign wr_set     = w_wr_set;
  assign bce        = r_bce;
  assign bwaddr     = r_bwaddr;
  assign bwdata     = r_bwdata;

endmodule

// File: tb/tb_act_wr_port_pp.sv
// Directed bench for act_wr_port_pp: vector table for burst timing plus
// hand-written sequences for reset, set fill, stall and release.
module tb_act_wr_port_pp;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [12:0]  tran_time;
  logic         data_valid;
  logic [255:0] data_i;
  logic [1:0]   rel_i;
  logic         data_ready;
  logic         done;
  logic [1:0]   set_full;
  logic         wr_set;
  logic [3:0]   bce;
  logic [59:0]  bwaddr;
  logic [511:0] bwdata;

  int n_checks = 0;
  int n_errors = 0;

  act_wr_port_pp dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tran_time  (tran_time),
    .data_valid (data_valid),
    .data_i     (data_i),
    .data_ready (data_ready),
    .done       (done),
    .rel_i      (rel_i),
    .set_full   (set_full),
    .wr_set     (wr_set),
    .bce        (bce),
    .bwaddr     (bwaddr),
    .bwdata     (bwdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic [12:0]  tt;
    logic         vld;
    logic [255:0] d;
    logic         e_rdy;
    logic [3:0]   e_bce;
    logic [14:0]  e_addr;
    logic [255:0] e_d;
    logic         e_done;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [255:0] pat(input int n);
    return {8{32'hA5A50000 + n}};
  endfunction

  function automatic vec_t mk(input logic st, input logic [12:0] tt, input logic vld,
                              input logic [255:0] d, input logic e_rdy, input logic [3:0] e_bce,
                              input logic [14:0] e_addr, input logic [255:0] e_d,
                              input logic e_done);
    vec_t v;
    v.st = st; v.tt = tt; v.vld = vld; v.d = d; v.e_rdy = e_rdy;
    v.e_bce = e_bce; v.e_addr = e_addr; v.e_d = e_d; v.e_done = e_done;
    return v;
  endfunction

  // Streams valid beats until n writes appear; checks each write's enables, address and data.
  task automatic stream(input int n, input logic [14:0] a0, input logic [3:0] mask,
                        output logic last_done);
    int          seen;
    int          bad;
    logic [14:0] ea;
    seen = 0;
    bad  = 0;
    ea   = a0;
    last_done  = 1'b0;
    data_valid = 1'b1;
    for (int c = 0; c < n + 20 && seen < n; c++) begin
      data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      if (bce != 4'b0000) begin
        if (bce !== mask || bwaddr !== {4{ea}} || bwdata !== {data_i, data_i}) bad++;
        ea        = ea + 15'd16;
        seen++;
        last_done = done;
      end
    end
    data_valid = 1'b0;
    check("stream_writes", seen, n);
    check("stream_bad_writes", bad, 0);
  endtask

  initial begin
    logic d;
    int   nb;
    rst = 1'b1; start = 1'b0; tran_time = '0; data_valid = 1'b0; data_i = '0; rel_i = '0;

    tbl[0]  = mk(1, 4, 0, '0,     0, 4'h0,  0, '0,     0);
    tbl[1]  = mk(0, 0, 1, pat(1), 1, 4'h3,  0, pat(1), 0);
    tbl[2]  = mk(0, 0, 1, pat(2), 1, 4'h3, 16, pat(2), 0);
    tbl[3]  = mk(0, 0, 1, pat(3), 1, 4'h3, 32, pat(3), 0);
    tbl[4]  = mk(0, 0, 1, pat(4), 1, 4'h3, 48, pat(4), 1);
    tbl[5]  = mk(0, 0, 1, pat(5), 0, 4'h0, 48, pat(4), 0);
    tbl[6]  = mk(0, 0, 1, pat(5), 0, 4'h0, 48, pat(4), 0);
    tbl[7]  = mk(1, 3, 0, '0,     0, 4'h0, 48, pat(4), 0);
    tbl[8]  = mk(0, 0, 1, pat(6), 1, 4'h3, 64, pat(6), 0);
    tbl[9]  = mk(1, 9, 0, pat(7), 1, 4'h0, 64, pat(6), 0);
    tbl[10] = mk(0, 0, 1, pat(7), 1, 4'h3, 80, pat(7), 0);
    tbl[11] = mk(0, 0, 0, '0,     1, 4'h0, 80, pat(7), 0);
    tbl[12] = mk(0, 0, 1, pat(8), 1, 4'h3, 96, pat(8), 1);
    tbl[13] = mk(0, 0, 0, '0,     0, 4'h0, 96, pat(8), 0);
    tbl[14] = mk(1, 0, 0, '0,     0, 4'h0, 96, pat(8), 1);
    tbl[15] = mk(0, 0, 1, pat(1), 0, 4'h0, 96, pat(8), 0);

    // Reset state.
    repeat (3) tick();
    check("rst_ready", data_ready, 0);
    check("rst_done", done, 0);
    check("rst_set_full", set_full, 0);
    check("rst_wr_set", wr_set, 0);
    check("rst_bce", bce, 0);
    check("rst_bwaddr", bwaddr, 0);
    check("rst_bwdata", bwdata, 0);
    rst = 1'b0;
    tick();

    // Bursts of 4 (always valid), 3 (toggling valid, stray start) and 0.
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; tran_time = tbl[i].tt; data_valid = tbl[i].vld; data_i = tbl[i].d;
      check($sformatf("row%0d_ready", i), data_ready, tbl[i].e_rdy);
      tick();
      check($sformatf("row%0d_bce", i), bce, tbl[i].e_bce);
      check($sformatf("row%0d_bwaddr", i), bwaddr, {4{tbl[i].e_addr}});
      check($sformatf("row%0d_bwdata", i), bwdata, {tbl[i].e_d, tbl[i].e_d});
      check($sformatf("row%0d_done", i), done, tbl[i].e_done);
    end
    start = 1'b0; data_valid = 1'b0;

    // Reset in the middle of an 8-beat burst, with beat 3 on the bus.
    start = 1'b1; tran_time = 13'd8;
    tick();
    start = 1'b0;
    stream(2, 15'd112, 4'b0011, d);
    data_valid = 1'b1;
    data_i = pat(9);
    #2 rst = 1'b1;
    #1;
    check("midrst_bce", bce, 0);
    check("midrst_bwaddr", bwaddr, 0);
    check("midrst_wr_set", wr_set, 0);
    check("midrst_set_full", set_full, 0);
    check("midrst_ready", data_ready, 0);
    tick();
    check("midrst_bce_edge", bce, 0);
    rst = 1'b0;
    data_valid = 1'b0;
    tick();

    // Fill set 0 from address 0 up to the limit.
    start = 1'b1; tran_time = 13'd2048;
    tick();
    start = 1'b0;
    stream(2048, 15'd0, 4'b0011, d);
    check("fill0_done", d, 1);
    check("fill0_last_addr", bwaddr, {4{15'd32752}});
    check("fill0_set_full", set_full, 2'b01);
    check("fill0_wr_set", wr_set, 1);
    tick();

    // Next beats go to set 1 from address 0.
    start = 1'b1; tran_time = 13'd2;
    tick();
    start = 1'b0;
    stream(2, 15'd0, 4'b1100, d);
    check("set1_done", d, 1);
    tick();

    // Fill set 1 mid-burst; set 0 still full so the last beat must stall.
    start = 1'b1; tran_time = 13'd2047;
    tick();
    start = 1'b0;
    stream(2046, 15'd32, 4'b1100, d);
    check("fill1_no_done", d, 0);
    check("fill1_set_full", set_full, 2'b11);
    check("fill1_wr_set", wr_set, 0);
    data_valid = 1'b1;
    data_i = pat(10);
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bce != 4'b0000 || data_ready != 1'b0) nb++;
    end
    check("stall_quiet", nb, 0);
    rel_i = 2'b01;
    check("stall_ready_during_rel", data_ready, 0);
    tick();
    rel_i = 2'b00;
    check("rel_set_full", set_full, 2'b10);
    check("rel_ready", data_ready, 1);
    tick();
    check("resume_bce", bce, 4'b0011);
    check("resume_bwaddr", bwaddr, 0);
    check("resume_bwdata", bwdata, {pat(10), pat(10)});
    check("resume_done", done, 1);
    data_valid = 1'b0;
    tick();
    rel_i = 2'b11;
    tick();
    rel_i = 2'b00;
    check("final_set_full", set_full, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/act_wr_port_pp.md
Name: act_wr_port_pp

Overview:
Parametrised successor of the activation SRAM write port. Accepts a burst of DATA_W-bit beats under a valid/ready handshake and splits each beat into NL = DATA_W/BANK_W lanes. Lanes are written into one of two bank sets (ping/pong), each NL banks wide. The block tracks set occupancy and back-pressures when both sets are full, until the downstream consumer releases a set. It sits between the activation producer (quantiser output) and the activation SRAM banks.

Parameters:
DATA_W, 256, input beat width; must be a multiple of BANK_W
BANK_W, 128, width of one SRAM bank word
ADDR_W, 15, bank address width
ADDR_STEP, 16, address increment per beat (byte addressing)
PP_ADDR_LIMIT, 32752, last address of a set; it must be a multiple of ADDR_STEP
CNT_W, 13, burst length counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse that begins a burst; ignored unless the block is IDLE
tran_time  in  CNT_W  beats in the burst; sampled on start
data_valid  in  1  producer beat valid
data_i  in  DATA_W  beat data; lane l = data_i[l*BANK_W +: BANK_W]
data_ready  out  1  block can accept a beat
done  out  1  one-cycle pulse when the burst completes
rel_i  in  2  consumer release pulse per set; clears set_full[s]
set_full  out  2  set s is full and awaiting release
wr_set  out  1  set currently being written (0=ping, 1=pong)
bce  out  2*NL  bank write enable; bank index = s*NL+l
bwaddr  out  2*NL*ADDR_W  per-bank address; all banks carry the same value
bwdata  out  2*NL*BANK_W  per-bank data; lane l is replicated to banks l and NL+l

Behaviour:
- Reset (asynchronous, on rst high): state IDLE; all outputs 0 (done, data_ready, set_full, wr_set, bce, bwaddr, bwdata); internal address 0; counter 0.
- States:
  - IDLE: start moves to BURST, loads cnt = tran_time. If tran_time==0, go to DONE instead and perform no writes.
  - BURST: data_ready = !set_full[wr_set].
  - DONE: one cycle; done=1; then back to IDLE.
- Beat accept = data_valid && data_ready. All SRAM outputs are registered. On an accepted beat at cycle t, at t+1:
  - bce bits of set wr_set are 1, all other bce bits are 0.
  - bwaddr = current address.
  - bwdata = the lanes of that beat.
  - In every cycle without an accept, bce = 0 and bwaddr/bwdata hold.
- Address is persistent across bursts (it is not cleared on start).
  - On each accept: address += ADDR_STEP.
  - If the accepted beat's address == PP_ADDR_LIMIT: set_full[wr_set] <= 1, wr_set toggles, address <= 0. This may happen mid-burst and the burst continues in the other set.
- If the new wr_set is still full, data_ready drops until rel_i[wr_set] arrives. Writing resumes at address 0 in the cycle after the release.
- The last accept of a burst (cnt reaches 1) moves the state to DONE. done is therefore coincident with the last bce cycle.
- rel_i for a set that is not full is ignored.
- rel_i[s] in the same cycle that set s becomes full cannot occur (s was empty), so it is treated as ignored.
- Counter width rule: tran_time values up to 2^CNT_W-1 are legal.
- start during BURST or DONE is ignored. Producer data_valid in IDLE is not accepted.

Optional Feature:
- Macro: ACT_WR_PORT_FLUSH_EN.
- When defined: input flush (1 bit) and output fill_addr (ADDR_W).
  - flush in IDLE with a non-zero address: fill_addr <= address - ADDR_STEP, set_full[wr_set] <= 1, wr_set toggles, address <= 0, done pulses one cycle later.
  - flush with a zero address does nothing.
- When undefined: neither port exists and partial sets are never handed over.

Decomposition:
- Shared package act_pkg holds:
  - localparams NL and SET_NUM=2;
  - state enum {IDLE, BURST, DONE};
  - function lane_of(beat, l).
- One natural sub-module: act_pp_tracker (wr_set, set_full, rel_i, fill event → stall). Datapath and FSM stay in the top module.

Test Plan:
- Reset mid-burst (rst at beat 3 of 8): all bce=0 next edge, address 0, wr_set 0, set_full 00.
- start, tran_time=4, data_valid always 1: bce=0b0011 for 4 cycles, bwaddr 0,16,32,48; done coincides with the 4th write; next burst starts at 64.
- Address preset near the limit (burst of 2048 from 0, then 2 more beats):
  - the beat at address 32752 writes set 0; set_full=01;
  - the next beat writes bce=0b1100 at address 0.
- Both sets full (no rel_i): data_ready=0 and no bce. rel_i=01 pulse → data_ready=1 next cycle and writes to set 0 resume at address 0.
- tran_time=0: done one cycle after start, no bce. start asserted during BURST is ignored (beat count unchanged).
- data_valid toggling 1,0,1,0: bce only follows accepted beats and the address advances only on accept.
